// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM states and the
// digit limits of the minutes:seconds.tenths time value.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] TENTH_MAX = 4'd9;
    localparam logic [5:0] SEC_MAX   = 6'd59;

    function automatic logic [5:0] clamp_sec(input logic [5:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every DIV enabled cycles.
// The count holds while en is low, so a paused run resumes mid-interval.
module tick_prescaler #(
    parameter int DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer core: command FSM, up/down minutes:seconds.tenths counter
// with wrap or saturate policy, and lap capture registers.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int MAX_MIN = 59,
    parameter int MIN_W   = 6,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    input  logic             mode,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    output logic [MIN_W-1:0] min,
    output logic [5:0]       sec,
    output logic [3:0]       tenth_sec,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic [3:0]       lap_tenth,
    output logic             lap_valid,
    output logic             running,
    output logic             expired
);

    localparam int DIV = CLK_HZ / 10;
    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    // Declared here rather than in the package because the minutes width is a
    // per-instance parameter.
    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [5:0]       sec;
        logic [3:0]       tenth;
    } time_t;

    localparam time_t TIME_MAX = {MAX_MIN_V, SEC_MAX, TENTH_MAX};

    state_e r_state;
    state_e w_state_next;
    time_t  r_time;
    time_t  w_time_next;
    time_t  w_time_up;
    time_t  w_time_down;
    time_t  r_lap;
    logic   r_mode;
    logic   w_mode_next;
    logic   r_lap_valid;
    logic   r_expired;
    logic   w_expire;
    logic   r_running;

    logic   w_load_acc;
    logic   w_stop_acc;
    logic   w_start_acc;
    logic   w_zero;
    logic   w_en;
    logic   w_clr;
    logic   w_tick;

    // Priority is resolved on the raw pulses: a higher command that is present
    // suppresses every lower one, even when it is itself ignored in this state.
    assign w_zero      = (r_time == '0);
    assign w_load_acc  = load && !clear && (r_state != RUN);
    assign w_stop_acc  = stop && !clear && !load && (r_state == RUN);
    assign w_start_acc = start && !clear && !load && !stop &&
                         (((r_state == IDLE) && !(mode && w_zero)) || (r_state == PAUSE));
    assign w_en        = (r_state == RUN) && !clear && !w_stop_acc;
    assign w_clr       = clear || w_load_acc;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_en),
        .clr     (w_clr),
        .tick    (w_tick)
    );

    always_comb begin
        w_time_up = r_time;
        if (r_time.tenth != TENTH_MAX) begin
            w_time_up.tenth = r_time.tenth + 4'd1;
        end else begin
            w_time_up.tenth = '0;
            if (r_time.sec != SEC_MAX) begin
                w_time_up.sec = r_time.sec + 6'd1;
            end else begin
                w_time_up.sec = '0;
                w_time_up.min = r_time.min + MIN_W'(1);
            end
        end
    end

    always_comb begin
        w_time_down = r_time;
        if (r_time.tenth != '0) begin
            w_time_down.tenth = r_time.tenth - 4'd1;
        end else begin
            w_time_down.tenth = TENTH_MAX;
            if (r_time.sec != '0) begin
                w_time_down.sec = r_time.sec - 6'd1;
            end else begin
                w_time_down.sec = SEC_MAX;
                w_time_down.min = r_time.min - MIN_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_time_next  = r_time;
        w_mode_next  = r_mode;
        w_expire     = 1'b0;
        if (clear) begin
            w_state_next = IDLE;
            w_time_next  = '0;
        end else if (w_load_acc) begin
            w_state_next      = IDLE;
            w_time_next.min   = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
            w_time_next.sec   = clamp_sec(load_sec);
            w_time_next.tenth = '0;
        end else if (w_stop_acc) begin
            w_state_next = PAUSE;
        end else if (w_start_acc) begin
            w_state_next = RUN;
            if (r_state == IDLE) begin
                w_mode_next = mode;
            end
        end else if (w_tick) begin
            if (!r_mode) begin
                if (r_time == TIME_MAX) begin
                    if (WRAP != 0) begin
                        w_time_next = '0;
                    end else begin
                        w_state_next = DONE;
                        w_expire     = 1'b1;
                    end
                end else begin
                    w_time_next = w_time_up;
                end
            end else begin
                w_time_next = w_time_down;
                if (w_time_down == '0) begin
                    w_state_next = DONE;
                    w_expire     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_mode    <= 1'b0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_time    <= w_time_next;
            r_mode    <= w_mode_next;
            r_expired <= w_expire;
            r_running <= (w_state_next == RUN);
        end
    end

    // Lap samples the pre-tick time registered in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap && (r_state != IDLE)) begin
            r_lap       <= r_time;
            r_lap_valid <= 1'b1;
        end
    end

    assign min       = r_time.min;
    assign sec       = r_time.sec;
    assign tenth_sec = r_time.tenth;
    assign lap_min   = r_lap.min;
    assign lap_sec   = r_lap.sec;
    assign lap_tenth = r_lap.tenth;
    assign lap_valid = r_lap_valid;
    assign running   = r_running;
    assign expired   = r_expired;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a wrapping and a saturating instance share the
// same stimulus and are compared against a total-tenths reference model.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 100;
    localparam int DIV     = 10;
    localparam int MAX_MIN = 2;
    localparam int MIN_W   = 6;
    localparam int FULL    = (MAX_MIN + 1) * 600;
    localparam int VW      = 35;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic             mode = 1'b0, load = 1'b0;
    logic [MIN_W-1:0] load_min = '0;
    logic [5:0]       load_sec = '0;

    logic [MIN_W-1:0] min_a, lap_min_a, min_b, lap_min_b;
    logic [5:0]       sec_a, lap_sec_a, sec_b, lap_sec_b;
    logic [3:0]       tenth_a, lap_tenth_a, tenth_b, lap_tenth_b;
    logic             lap_valid_a, running_a, expired_a;
    logic             lap_valid_b, running_b, expired_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, index 0 = wrapping instance, 1 = saturating instance.
    int m_state[2];
    int m_total[2];
    int m_pre[2];
    int m_lap[2];
    bit m_down[2];
    bit m_lapv[2];
    bit m_exp[2];

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN), .MIN_W(MIN_W), .WRAP(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
        .min(min_a), .sec(sec_a), .tenth_sec(tenth_a), .lap_min(lap_min_a),
        .lap_sec(lap_sec_a), .lap_tenth(lap_tenth_a), .lap_valid(lap_valid_a),
        .running(running_a), .expired(expired_a)
    );

    stopwatch_core #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN), .MIN_W(MIN_W), .WRAP(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
        .min(min_b), .sec(sec_b), .tenth_sec(tenth_b), .lap_min(lap_min_b),
        .lap_sec(lap_sec_b), .lap_tenth(lap_tenth_b), .lap_valid(lap_valid_b),
        .running(running_b), .expired(expired_b)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE; m_total[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
            m_down[k] = 1'b0; m_lapv[k] = 1'b0; m_exp[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int t;
        int lm;
        int ls;
        t = m_total[k];
        m_exp[k] = 1'b0;
        if (!clear && lap && m_state[k] != S_IDLE) begin
            m_lap[k] = t;
            m_lapv[k] = 1'b1;
        end
        if (clear) begin
            m_state[k] = S_IDLE; m_total[k] = 0; m_pre[k] = 0; m_lap[k] = 0; m_lapv[k] = 1'b0;
        end else if (load && m_state[k] != S_RUN) begin
            lm = (int'(load_min) > MAX_MIN) ? MAX_MIN : int'(load_min);
            ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
            m_total[k] = lm * 600 + ls * 10;
            m_pre[k] = 0;
            m_state[k] = S_IDLE;
        end else if (stop && !load && m_state[k] == S_RUN) begin
            m_state[k] = S_PAUSE;
        end else if (start && !load && !stop && m_state[k] == S_IDLE) begin
            if (!(mode && t == 0)) begin
                m_state[k] = S_RUN;
                m_down[k] = mode;
            end
        end else if (start && !load && !stop && m_state[k] == S_PAUSE) begin
            m_state[k] = S_RUN;
        end else if (m_state[k] == S_RUN) begin
            if (m_pre[k] == DIV - 1) begin
                m_pre[k] = 0;
                if (!m_down[k]) begin
                    if (t == FULL - 1) begin
                        if (k == 0) m_total[k] = 0;
                        else begin m_state[k] = S_DONE; m_exp[k] = 1'b1; end
                    end else begin
                        m_total[k] = t + 1;
                    end
                end else begin
                    m_total[k] = t - 1;
                    if (m_total[k] == 0) begin m_state[k] = S_DONE; m_exp[k] = 1'b1; end
                end
            end else begin
                m_pre[k] = m_pre[k] + 1;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input int k);
        int t;
        int l;
        t = m_total[k];
        l = m_lap[k];
        return {6'(t / 600), 6'((t / 10) % 60), 4'(t % 10),
                6'(l / 600), 6'((l / 10) % 60), 4'(l % 10),
                m_lapv[k], (m_state[k] == S_RUN), m_exp[k]};
    endfunction

    function automatic logic [VW-1:0] obs_vec(input int k);
        if (k == 0)
            return {min_a, sec_a, tenth_a, lap_min_a, lap_sec_a, lap_tenth_a,
                    lap_valid_a, running_a, expired_a};
        return {min_b, sec_b, tenth_b, lap_min_b, lap_sec_b, lap_tenth_b,
                lap_valid_b, running_b, expired_b};
    endfunction

    // One clock edge; the model consumes the same inputs the DUT sampled.
    task automatic tick_clk();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== '0) begin
                n_errors++;
                $display("FAIL reset dut%0d got %h exp %h", k, obs_vec(k), {VW{1'b0}});
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        mode = 1'b0;
        start = 1'b1;
        tick_clk();
        n_checks++;
        if (running_a !== 1'b1 || running_b !== 1'b1) begin
            n_errors++;
            $display("FAIL start_running got %b%b exp 11", running_a, running_b);
        end
        for (int i = 1; i <= 100; i++) begin
            tick_clk();
            if (i == 9) begin
                n_checks++;
                if (tenth_a !== 4'd0 || tenth_b !== 4'd0) begin
                    n_errors++;
                    $display("FAIL first_tick_early got %0d/%0d exp 0", tenth_a, tenth_b);
                end
            end
            if (i == 10) begin
                n_checks++;
                if (tenth_a !== 4'd1 || tenth_b !== 4'd1) begin
                    n_errors++;
                    $display("FAIL first_tick got %0d/%0d exp 1", tenth_a, tenth_b);
                end
            end
        end
        n_checks++;
        if (sec_a !== 6'd1 || tenth_a !== 4'd0 || sec_b !== 6'd1 || tenth_b !== 4'd0) begin
            n_errors++;
            $display("FAIL one_second got %0d.%0d exp 1.0", sec_a, tenth_a);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL count_up_model dut%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_pause();
        clear = 1'b1;
        tick_clk();
        mode = 1'b0;
        start = 1'b1;
        tick_clk();
        repeat (353) tick_clk();
        stop = 1'b1;
        tick_clk();
        repeat (50) tick_clk();
        n_checks++;
        if (sec_a !== 6'd3 || tenth_a !== 4'd5 || running_a !== 1'b0 || sec_b !== 6'd3 || tenth_b !== 4'd5) begin
            n_errors++;
            $display("FAIL pause_hold got %0d.%0d run %b exp 3.5 run 0", sec_a, tenth_a, running_a);
        end
        start = 1'b1;
        tick_clk();
        for (int i = 1; i <= 7; i++) begin
            tick_clk();
            if (i == 6) begin
                n_checks++;
                if (tenth_a !== 4'd5 || tenth_b !== 4'd5) begin
                    n_errors++;
                    $display("FAIL resume_early got %0d exp 5", tenth_a);
                end
            end
        end
        n_checks++;
        if (tenth_a !== 4'd6 || tenth_b !== 4'd6) begin
            n_errors++;
            $display("FAIL resume_tick got %0d exp 6", tenth_a);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL pause_model dut%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_countdown();
        clear = 1'b1;
        tick_clk();
        load = 1'b1; load_min = 6'd0; load_sec = 6'd1;
        tick_clk();
        mode = 1'b1;
        start = 1'b1;
        tick_clk();
        repeat (99) tick_clk();
        n_checks++;
        if (sec_a !== 6'd0 || tenth_a !== 4'd1 || expired_a !== 1'b0 || running_a !== 1'b1) begin
            n_errors++;
            $display("FAIL down_before_zero got %0d.%0d exp 0.1", sec_a, tenth_a);
        end
        tick_clk();
        n_checks++;
        if (obs_vec(0) !== 35'h1 || obs_vec(1) !== 35'h1) begin
            n_errors++;
            $display("FAIL down_expire got %h/%h exp %h", obs_vec(0), obs_vec(1), 35'h1);
        end
        tick_clk();
        n_checks++;
        if (expired_a !== 1'b0 || expired_b !== 1'b0) begin
            n_errors++;
            $display("FAIL expire_width got %b%b exp 00", expired_a, expired_b);
        end
        load = 1'b1; load_min = 6'd0; load_sec = 6'd0;
        tick_clk();
        mode = 1'b1;
        start = 1'b1;
        tick_clk();
        n_checks++;
        if (running_a !== 1'b0 || running_b !== 1'b0) begin
            n_errors++;
            $display("FAIL down_zero_start got %b%b exp 00", running_a, running_b);
        end
    endtask

    task automatic test_wrap();
        clear = 1'b1;
        tick_clk();
        load = 1'b1; load_min = 6'd2; load_sec = 6'd59;
        tick_clk();
        mode = 1'b0;
        start = 1'b1;
        tick_clk();
        repeat (90) tick_clk();
        n_checks++;
        if (min_a !== 6'd2 || sec_a !== 6'd59 || tenth_a !== 4'd9 || tenth_b !== 4'd9) begin
            n_errors++;
            $display("FAIL at_max got %0d:%0d.%0d exp 2:59.9", min_a, sec_a, tenth_a);
        end
        repeat (10) tick_clk();
        n_checks++;
        if (min_a !== 6'd0 || sec_a !== 6'd0 || tenth_a !== 4'd0 || running_a !== 1'b1 || expired_a !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap got %0d:%0d.%0d run %b exp %b exp 0:0.0 run 1 exp 0",
                     min_a, sec_a, tenth_a, running_a, expired_a);
        end
        n_checks++;
        if (min_b !== 6'd2 || sec_b !== 6'd59 || tenth_b !== 4'd9 || running_b !== 1'b0 || expired_b !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate got %0d:%0d.%0d run %b exp %b exp 2:59.9 run 0 exp 1",
                     min_b, sec_b, tenth_b, running_b, expired_b);
        end
        tick_clk();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL wrap_model dut%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_lap();
        clear = 1'b1;
        tick_clk();
        lap = 1'b1;
        tick_clk();
        n_checks++;
        if (lap_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL lap_idle got %b exp 0", lap_valid_a);
        end
        mode = 1'b0;
        start = 1'b1;
        tick_clk();
        repeat (139) tick_clk();
        lap = 1'b1;
        tick_clk();
        n_checks++;
        if (lap_sec_a !== 6'd1 || lap_tenth_a !== 4'd3 || lap_valid_a !== 1'b1 ||
            sec_a !== 6'd1 || tenth_a !== 4'd4) begin
            n_errors++;
            $display("FAIL lap_tick got lap %0d.%0d time %0d.%0d exp lap 1.3 time 1.4",
                     lap_sec_a, lap_tenth_a, sec_a, tenth_a);
        end
        lap = 1'b1;
        clear = 1'b1;
        tick_clk();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== '0) begin
                n_errors++;
                $display("FAIL lap_clear dut%0d got %h exp %h", k, obs_vec(k), {VW{1'b0}});
            end
        end
    endtask

    task automatic test_clamp_reset();
        load = 1'b1; load_min = 6'd7; load_sec = 6'd63;
        tick_clk();
        n_checks++;
        if (min_a !== 6'd2 || sec_a !== 6'd59 || tenth_a !== 4'd0 || min_b !== 6'd2 || sec_b !== 6'd59) begin
            n_errors++;
            $display("FAIL clamp got %0d:%0d.%0d exp 2:59.0", min_a, sec_a, tenth_a);
        end
        mode = 1'b0;
        start = 1'b1;
        tick_clk();
        repeat (25) tick_clk();
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== '0) begin
                n_errors++;
                $display("FAIL reset_mid_run dut%0d got %h exp %h", k, obs_vec(k), {VW{1'b0}});
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 99) < 6);
            stop     = ($urandom_range(0, 99) < 3);
            clear    = ($urandom_range(0, 199) < 1);
            load     = ($urandom_range(0, 99) < 2);
            lap      = ($urandom_range(0, 99) < 5);
            mode     = 1'($urandom_range(0, 1));
            load_min = 6'($urandom_range(0, 7));
            load_sec = 6'($urandom_range(0, 63));
            tick_clk();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_errors++;
                    if (bad < 10)
                        $display("FAIL random cyc %0d dut%0d got %h exp %h", i, k, obs_vec(k), exp_vec(k));
                    bad++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_pause();
        test_countdown();
        test_wrap();
        test_lap();
        test_clamp_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
